// File: rtl/counter_window_pkg.sv
// Shared types and default widths for the windowed event counter controller.
package counter_window_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/counter_window_ctrl_event_counter.sv
// Event counter with clear; wraps and flags overflow, or saturates when
// COUNTER_WINDOW_CTRL_SATURATE_EN is defined.
module event_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (count == CNT_MAX) begin
`ifdef COUNTER_WINDOW_CTRL_SATURATE_EN
        count <= CNT_MAX;
`else
        count <= '0;
`endif
        // sticky until the next clear
        ovf <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_window_ctrl.sv
// Counts rising edges of `in` over a programmable window and hands the count
// out on a valid/ready port. Build option: COUNTER_WINDOW_CTRL_SATURATE_EN.
//
// state | meaning
// IDLE  | waiting for start; abort ignored
// COUNT | window open, rising edges of in are counted
// DONE  | result captured/presented, waiting for result_ready
module counter_window_ctrl
  import counter_window_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] cfg_window,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow
);

  state_t           state;
  state_t           state_nxt;
  logic             in_q;
  logic             edge_evt;
  logic [WIN_W-1:0] win_rem;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_ovf;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             win_load;
  logic             win_dec;
  logic             res_load;
  logic             rv_clr;

  assign edge_evt = in & ~in_q;
  assign cnt_inc  = (state == COUNT) & edge_evt;
  assign busy     = (state != IDLE);

  event_counter #(
    .CNT_W(CNT_W)
  ) u_event_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .count(cnt_val),
    .ovf  (cnt_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    win_load  = 1'b0;
    win_dec   = 1'b0;
    res_load  = 1'b0;
    rv_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          if (cfg_window != '0) begin
            win_load  = 1'b1;
            state_nxt = COUNT;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      COUNT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          win_dec = 1'b1;
          if (win_rem == WIN_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        // first DONE cycle captures the settled count, so the last window
        // cycle's event is included
        if (!result_valid) begin
          res_load = 1'b1;
        end else if (result_ready) begin
          rv_clr    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q         <= 1'b0;
      win_rem      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      in_q <= in;
      if (win_load) begin
        win_rem <= cfg_window;
      end else if (win_dec) begin
        win_rem <= win_rem - WIN_W'(1);
      end
      if (res_load) begin
        result       <= cnt_val;
        overflow     <= cnt_ovf;
        result_valid <= 1'b1;
      end else if (rv_clr) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_window_ctrl.sv
// Scoreboard bench for counter_window_ctrl; expected results are queued at
// start and compared when the result handshake completes.
module tb_counter_window_ctrl;

  localparam int CNT_W = 8;
  localparam int WIN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in;
  logic             start;
  logic             abort;
  logic [WIN_W-1:0] cfg_window;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             result_ready;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_start  = 0;
  logic [CNT_W-1:0] last_result = '0;

  typedef struct {
    logic [CNT_W-1:0] res;
    logic             ovf;
    int               lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  counter_window_ctrl #(
    .CNT_W(CNT_W),
    .WIN_W(WIN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .start       (start),
    .abort       (abort),
    .cfg_window  (cfg_window),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .overflow    (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [CNT_W-1:0] res, input logic ovf, input int lat);
    exp_t e;
    e.res = res;
    e.ovf = ovf;
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic issue_start(input logic [WIN_W-1:0] w);
    cfg_window = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    t_start = cyc;
  endtask

  // waits for result_valid, compares against the queue head, optionally holds
  // off result_ready for `hold` cycles while pulsing start, then handshakes
  task automatic collect_result(input string name, input int hold);
    exp_t e;
    int   waited;
    waited = 0;
    while (result_valid !== 1'b1 && waited < 2000) begin
      tick();
      waited++;
    end
    n_checks++;
    if (result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: result_valid=%b after %0d cycles, required 1", name, result_valid, waited);
      return;
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected: result=%0d with empty scoreboard", name, result);
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (cyc - t_start != e.lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, cyc - t_start, e.lat);
    end
    n_checks++;
    if (result !== e.res) begin
      n_fail++;
      $display("FAIL %s_result: got %0d, required %0d", name, result, e.res);
    end
    n_checks++;
    if (overflow !== e.ovf) begin
      n_fail++;
      $display("FAIL %s_overflow: got %b, required %b", name, overflow, e.ovf);
    end
    for (int i = 0; i < hold; i++) begin
      if (i == hold / 2) begin
        start = 1'b1;
        cfg_window = 16'd2;
      end else begin
        start = 1'b0;
      end
      tick();
      n_checks++;
      if (result_valid !== 1'b1 || busy !== 1'b1 || result !== e.res) begin
        n_fail++;
        $display("FAIL %s_hold%0d: valid=%b busy=%b result=%0d, required 1 1 %0d",
                 name, i, result_valid, busy, result, e.res);
      end
    end
    start = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    n_checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_handshake: valid=%b busy=%b, required 0 0", name, result_valid, busy);
    end
    last_result = e.res;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    cfg_window = 16'd5;
    result_ready = 1'b0;
    tick();
    tick();
    in = 1'b0;
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: busy=%b valid=%b result=%0d ovf=%b, required all 0",
               busy, result_valid, result, overflow);
    end
  endtask

  task automatic test_basic();
    issue_start(16'd20);
    push_exp(8'd3, 1'b0, 21);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got %b, required 1", busy);
    end
    for (int i = 0; i < 20; i++) begin
      in = (i == 3 || i == 8 || i == 15);
      tick();
    end
    in = 1'b0;
    collect_result("basic", 0);
  endtask

  task automatic test_held_high();
    in = 1'b1;
    tick();
    tick();
    issue_start(16'd10);
    push_exp(8'd0, 1'b0, 11);
    for (int i = 0; i < 10; i++) tick();
    collect_result("held_high", 0);
    in = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] exp_res;
`ifdef COUNTER_WINDOW_CTRL_SATURATE_EN
    exp_res = 8'd255;
`else
    exp_res = 8'd44;
`endif
    in = 1'b0;
    tick();
    issue_start(16'd600);
    push_exp(exp_res, 1'b1, 601);
    for (int i = 0; i < 600; i++) begin
      in = (i % 2 == 0);
      tick();
    end
    in = 1'b0;
    collect_result("wrap", 0);
  endtask

  task automatic test_abort();
    int seen_valid;
    issue_start(16'd50);
    for (int i = 0; i < 30; i++) begin
      in = (i % 4 == 1);
      tick();
    end
    in = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b valid=%b, required 0 0", busy, result_valid);
    end
    seen_valid = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (result_valid === 1'b1) seen_valid++;
    end
    n_checks++;
    if (seen_valid != 0) begin
      n_fail++;
      $display("FAIL abort_no_result: valid seen %0d cycles, required 0", seen_valid);
    end
    n_checks++;
    if (result !== last_result) begin
      n_fail++;
      $display("FAIL abort_result_kept: got %0d, required %0d", result, last_result);
    end
    // abort on the final window cycle wins over completion
    issue_start(16'd4);
    for (int i = 0; i < 4; i++) begin
      abort = (i == 3);
      tick();
    end
    abort = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy !== 1'b0 || result_valid === 1'b1) seen_valid++;
      tick();
    end
    n_checks++;
    if (seen_valid != 0) begin
      n_fail++;
      $display("FAIL abort_last_cycle: busy/valid active %0d cycles, required 0", seen_valid);
    end
    issue_start(16'd5);
    push_exp(8'd2, 1'b0, 6);
    for (int i = 0; i < 5; i++) begin
      in = (i == 0 || i == 2);
      tick();
    end
    in = 1'b0;
    collect_result("after_abort", 0);
  endtask

  task automatic test_backpressure();
    issue_start(16'd3);
    push_exp(8'd1, 1'b0, 4);
    for (int i = 0; i < 3; i++) begin
      in = (i == 1);
      tick();
    end
    in = 1'b0;
    collect_result("backpressure", 7);
    tick();
    n_checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_not_queued: busy=%b valid=%b, required 0 0", busy, result_valid);
    end
  endtask

  task automatic test_rst_mid();
    issue_start(16'd20);
    for (int i = 0; i < 6; i++) begin
      in = (i == 1 || i == 4);
      tick();
    end
    in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: busy=%b valid=%b result=%0d ovf=%b, required all 0",
               busy, result_valid, result, overflow);
    end
    tick();
    issue_start(16'd5);
    push_exp(8'd1, 1'b0, 6);
    for (int i = 0; i < 5; i++) begin
      in = (i == 2);
      tick();
    end
    in = 1'b0;
    collect_result("after_rst", 0);
  endtask

  task automatic test_zero_window();
    issue_start(16'd0);
    push_exp(8'd0, 1'b0, 1);
    collect_result("zero_window", 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_high();
    test_wrap();
    test_abort();
    test_backpressure();
    test_rst_mid();
    test_zero_window();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_window_ctrl.md
Name: counter_window_ctrl

Overview:
- Controller that sequences an event counter over a programmable measurement window.
- On a start request it clears the count, gates rising edges of `in` into the counter for exactly `cfg_window` cycles, then presents the captured count on a valid/ready result interface.
- Sits between software/config logic and the event-counting datapath, so counts are taken per-window instead of free-running.

Parameters:
- CNT_W, 8, width of the event count and result.
- WIN_W, 16, width of the window-length configuration and internal window down-counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  1  event input; each 0->1 transition is one event.
- start  input  1  request a measurement; sampled only in IDLE.
- abort  input  1  cancel a measurement in progress; no result produced.
- cfg_window  input  WIN_W  window length in cycles; latched on accepted start.
- busy  output  1  high in COUNT and DONE.
- result  output  CNT_W  captured count; stable while result_valid is high.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts result.
- overflow  output  1  count exceeded 2^CNT_W-1 during the window; qualified by result_valid.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, busy=0, result=0, result_valid=0, overflow=0, count=0, window counter=0, in_q=0.
- Edge detect: in_q registers `in` every cycle in all states. event = in & ~in_q.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - start=1 with cfg_window!=0 -> COUNT. Latch win_rem=cfg_window, clear count and overflow.
  - start=1 with cfg_window==0 -> DONE with result=0, overflow=0.
  - start=0 -> stay in IDLE.
- COUNT:
  - Each cycle, count increments by 1 if event.
  - win_rem decrements by 1 each cycle.
  - On the cycle win_rem==1: include that cycle's event, load result with the final count, go to DONE.
  - Exactly cfg_window cycles are evaluated.
- Latency: start accepted at edge T; count cycles are T+1 through T+W; result_valid rises after edge T+W+1 (registered output).
- abort in COUNT -> IDLE next cycle. count is discarded, result_valid stays 0, and result keeps its previous value.
  - abort on the same cycle as win_rem==1 takes priority; no result is produced.
  - abort in IDLE or DONE is ignored.
- DONE:
  - result_valid=1; result and overflow are held.
  - result_valid & result_ready -> IDLE, result_valid=0 next cycle. result keeps its value.
  - result_valid must not drop without a handshake.
- start outside IDLE is ignored. It is not queued.
- A new start is accepted in IDLE, at the earliest the cycle after the handshake.
- Wrap: count at 2^CNT_W-1 plus an event wraps to 0 and sets overflow. overflow is sticky for the window.
- rst mid-operation (COUNT or DONE) returns to the full reset state next cycle; any pending result is lost.

Optional Feature:
- Macro: COUNTER_WINDOW_CTRL_SATURATE_EN.
- Defined: count saturates at 2^CNT_W-1. Further events leave the count unchanged; overflow is still set on the first dropped event.
- Undefined: count wraps modulo 2^CNT_W and overflow is set, as above.
- All other behaviour is identical.

Decomposition:
- Package counter_window_pkg:
  - enum state_t {IDLE, COUNT, DONE}
  - default-width localparams for CNT_W/WIN_W
- Sub-module event_counter (CNT_W):
  - inputs: clk, rst, clr, inc
  - outputs: count, ovf
  - holds the edge-gated counter and wrap/saturate logic, including the macro branch.
- Controller FSM, window down-counter, edge detect and result register stay in counter_window_ctrl.

Test Plan:
- Reset, then start with cfg_window=20; drive `in` with 3 clean pulses inside the window -> result_valid 21 cycles after start edge, result=3, overflow=0.
- cfg_window=10; hold in=1 across the window start (rose before start); no further edges -> result=0, since only 0->1 edges inside the window count.
- CNT_W=8, cfg_window=600; toggle `in` every cycle (300 edges):
  - without macro -> result=44 (300 mod 256), overflow=1
  - with COUNTER_WINDOW_CTRL_SATURATE_EN -> result=255, overflow=1
- Start window=50, assert abort at cycle 30 -> busy=0 next cycle, result_valid never asserts; a following start with window=5 and 2 edges -> result=2.
- Hold result_ready=0 for 7 cycles after result_valid, pulse start meanwhile -> result stable, start ignored, busy=1; result_ready=1 -> IDLE next cycle.
- cfg_window=0 start -> result_valid after 1 cycle, result=0. Separately, assert rst during COUNT -> all outputs 0 next cycle.
